// File: rtl/load_mem_reader.sv
// Streams NUM_SAMPLES words from the sample RAM (BASE_ADDR upward) to a valid/ready consumer.
// RAM read latency absorbed by a 2-entry buffer; reads are throttled so the buffer never overflows.
module load_mem_reader #(
    parameter int ADDR_W      = 11,
    parameter int DATA_W      = 10,
    parameter int NUM_SAMPLES = 10,
    parameter int BASE_ADDR   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0]   NUM      = (ADDR_W+1)'(NUM_SAMPLES);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FINISH
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   issued_q, issued_d;
    logic [ADDR_W:0]   accepted_q, accepted_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              inflight_q;
    logic [DATA_W-1:0] buf_q [2];
    logic              rd_ptr_q, wr_ptr_q;
    logic [1:0]        count_q, count_d;
    logic              push, pop, rd_en;
    logic [2:0]        occ;

    always_comb begin
        pop        = (count_q != 2'd0) && sample_ready;
        push       = inflight_q;
        // Occupancy the buffer will have once everything already requested lands.
        occ        = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        count_d    = count_q + {1'b0, push} - {1'b0, pop};
        state_d    = state_q;
        issued_d   = issued_q;
        accepted_d = accepted_q;
        addr_d     = addr_q;
        rd_en      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_RUN;
                    issued_d   = '0;
                    accepted_d = '0;
                    addr_d     = BASE;
                end
            end
            S_RUN: begin
                if ((issued_q < NUM) && (occ < 3'd2)) begin
                    rd_en    = 1'b1;
                    issued_d = issued_q + CNT_ONE;
                    // Address stops on the last sample rather than running one past it.
                    if (issued_d < NUM) begin
                        addr_d = addr_q + ADDR_ONE;
                    end
                end
                if (pop) begin
                    accepted_d = accepted_q + CNT_ONE;
                    if (accepted_d == NUM) begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            issued_q   <= '0;
            accepted_q <= '0;
            addr_q     <= BASE;
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
        end else begin
            state_q    <= state_d;
            issued_q   <= issued_d;
            accepted_q <= accepted_d;
            addr_q     <= addr_d;
            inflight_q <= rd_en;
            count_q    <= count_d;
            if (push) begin
                buf_q[wr_ptr_q] <= mem_rdata;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    assign mem_addr     = addr_q;
    assign mem_rd_en    = rd_en;
    assign sample_out   = buf_q[rd_ptr_q];
    assign sample_valid = (count_q != 2'd0);
    assign busy         = (state_q == S_RUN);
    assign done         = (state_q == S_FINISH);

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && (count_q == 2'd2)));

    a_read_bound: assert property (@(posedge clk) disable iff (rst)
        rd_en |-> (issued_q < NUM));

    a_hold_stable: assert property (@(posedge clk) disable iff (rst)
        (sample_valid && !sample_ready) |=> (sample_valid && $stable(sample_out)));

endmodule

// File: tb/tb_load_mem_reader.sv
module tb_load_mem_reader;
    localparam int AW = 11;
    localparam int DW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, ready;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_en;
    logic [DW-1:0] mem_rdata, sample_out;
    logic          sample_valid, busy, done;

    logic          start1, ready1;
    logic [AW-1:0] mem_addr1;
    logic          mem_rd_en1;
    logic [DW-1:0] mem_rdata1, sample_out1;
    logic          sample_valid1, busy1, done1;

    load_mem_reader dut (
        .clk(clk), .rst(rst), .start(start),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
        .sample_out(sample_out), .sample_valid(sample_valid), .sample_ready(ready),
        .busy(busy), .done(done)
    );

    load_mem_reader #(.ADDR_W(AW), .DATA_W(DW), .NUM_SAMPLES(1), .BASE_ADDR(2047)) dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .mem_addr(mem_addr1), .mem_rd_en(mem_rd_en1), .mem_rdata(mem_rdata1),
        .sample_out(sample_out1), .sample_valid(sample_valid1), .sample_ready(ready1),
        .busy(busy1), .done(done1)
    );

    // RAM model: one-cycle read latency
    logic [DW-1:0] ram [2**AW];
    always @(posedge clk) begin
        if (mem_rd_en)  mem_rdata  <= ram[mem_addr];
        if (mem_rd_en1) mem_rdata1 <= ram[mem_addr1];
    end

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int exp1_q[$];
    int xfer_cnt = 0, rd_cnt = 0, done_cnt = 0;
    int xfer1_cnt = 0, rd1_cnt = 0, done1_cnt = 0;
    int hold_val = 0;
    bit prev_stall = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitor / scoreboard for the default instance
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            int pop_now;
            pop_now = (sample_valid && ready) ? 1 : 0;
            if (mem_rd_en) begin
                check("rd_addr", mem_addr, rd_cnt);
                check("rd_window", ((rd_cnt - xfer_cnt - pop_now) < 2) ? 1 : 0, 1);
                rd_cnt++;
            end
            if (prev_stall) begin
                check("hold_valid", sample_valid, 1);
                check("hold_data", sample_out, hold_val);
            end
            if (sample_valid && ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_xfer actual=%0d expected=none", sample_out);
                end else begin
                    check("sample", sample_out, exp_q.pop_front());
                end
                xfer_cnt++;
            end
            prev_stall = sample_valid && !ready;
            hold_val   = sample_out;
            if (done) begin
                done_cnt++;
                check("busy_at_done", busy, 0);
            end
        end
    end

    // Monitor / scoreboard for the single-sample top-of-memory instance
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_rd_en1) begin
                check("rd1_addr", mem_addr1, 2047);
                rd1_cnt++;
            end
            if (sample_valid1 && ready1) begin
                if (exp1_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_xfer1 actual=%0d expected=none", sample_out1);
                end else begin
                    check("sample1", sample_out1, exp1_q.pop_front());
                end
                xfer1_cnt++;
            end
            if (done1) done1_cnt++;
        end
    end

    // mode 0: ready high; 1: 5-cycle stall after first valid; 2: ready toggles; 3: extra starts
    task automatic run_test(input int mode);
        int cyc, stall, d0;
        bit stall_checked;
        rd_cnt = 0;
        xfer_cnt = 0;
        d0 = done_cnt;
        stall = 0;
        stall_checked = 1'b0;
        for (int i = 0; i < 10; i++) exp_q.push_back(100 + i);
        ready = (mode == 0 || mode == 3);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (done_cnt == d0 && cyc < 200) begin
            case (mode)
                1: ready = (stall >= 5);
                2: ready = cyc[0];
                3: start = (cyc == 5 || cyc == 13);
                default: ready = 1'b1;
            endcase
            @(negedge clk);
            if (mode == 0 || mode == 3) begin
                if (cyc == 1) check("busy_after_start", busy, 1);
                if (cyc == 2) check("valid_c2", sample_valid, 0);
                if (cyc == 3) check("valid_c3", sample_valid, 1);
                if (cyc == 13) check("done_c13", done, 1);
            end
            if (mode == 1 && sample_valid && !ready) stall++;
            if (mode == 1 && stall == 5 && !stall_checked) begin
                stall_checked = 1'b1;
                check("stall_reads", rd_cnt, 2);
                check("stall_head", sample_out, 100);
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        ready = 1'b1;
        check("run_timeout", (cyc < 200) ? 1 : 0, 1);
        check("xfers", xfer_cnt, 10);
        check("queue_empty", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        check("busy_idle", busy, 0);
        check("done_pulses", done_cnt - d0, 1);
        check("reads_total", rd_cnt, 10);
    endtask

    initial begin
        int n, d0;
        for (int i = 0; i < 2**AW; i++) ram[i] = '0;
        for (int i = 0; i < 10; i++) ram[i] = DW'(100 + i);
        ram[2047] = DW'(777);
        rst = 1'b1; start = 1'b0; ready = 1'b0; start1 = 1'b0; ready1 = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", sample_valid, 0);
        check("rst_rd_en", mem_rd_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sout", sample_out, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_addr1", mem_addr1, 2047);
        rst = 1'b0;
        @(posedge clk); #1;

        run_test(0);
        run_test(1);
        run_test(2);
        run_test(3);

        // reset after the 4th transfer
        rd_cnt = 0;
        xfer_cnt = 0;
        d0 = done_cnt;
        for (int i = 0; i < 10; i++) exp_q.push_back(100 + i);
        ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (xfer_cnt < 4 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rst_wait_timeout", (n < 50) ? 1 : 0, 1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", sample_valid, 0);
        check("mid_rst_rd_en", mem_rd_en, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_sout", sample_out, 0);
        check("mid_rst_addr", mem_addr, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_no_done", done_cnt - d0, 0);
        @(posedge clk); #1;
        run_test(0);

        // single sample at the top of the address space
        exp1_q.push_back(777);
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        n = 0;
        while (done1_cnt == 0 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        check("n1_timeout", (n < 30) ? 1 : 0, 1);
        check("n1_reads", rd1_cnt, 1);
        check("n1_xfers", xfer1_cnt, 1);
        check("n1_done", done1_cnt, 1);
        check("n1_busy", busy1, 0);
        check("n1_queue", exp1_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
